// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: FSM encoding, fetch buffer entry, instruction size.
// Pure declarations; no latency or backpressure of its own.
// Imported by the fetch top, its buffer and its interface users.
package riscv_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory request pair, redirect input, decode handshake.
// Wiring only; timing is defined by the fetch stage driving it.
// Decode backpressure is carried by if_ready against if_valid.
interface instruction_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc,
    input  if_ready,
    output fetch_fault
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc,
    output if_ready,
    input  fetch_fault
  );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer holding {instr, pc} entries; head visible the cycle after push.
// Latency: 1 cycle push-to-head; flush is synchronous and beats push/pop.
// Backpressure: full/empty reported; caller must not push when full or pop when empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, requests imem, buffers {instr, pc} for decode.
// Latency: word fetched in cycle N is offered to decode in cycle N+1.
// Backpressure: fetch stalls while the buffer is full; redirect flushes and refetches.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  pc;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign bus.imem_addr = pc;
  assign pop           = !fifo_empty && bus.if_ready;
  assign push_entry    = '{instr: bus.imem_data, pc: pc};

  assign bus.if_valid  = !fifo_empty;
  assign bus.if_instr  = head.instr;
  assign bus.if_pc     = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid)
      state_d = (bus.redirect_pc[1:0] == 2'b00) ? RUN : FAULT;
  end

  always_comb begin
    bus.imem_req    = 1'b0;
    bus.fetch_fault = (state_q == FAULT);
    if (!rst && state_q == RUN && !bus.redirect_valid && !fifo_full)
      bus.imem_req = 1'b1;
  end

  // A misaligned target is still latched, word-aligned, so imem_addr never carries low bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     pc <= RESET_PC;
    else if (bus.redirect_valid) pc <= {bus.redirect_pc[31:2], 2'b00};
    else if (bus.imem_req)       pc <= pc + INSTR_BYTES;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (bus.imem_req),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, async-reset sequence, random run vs queue model.
module tb_instruction_fetch;

  localparam int DEPTH = 2;

  logic clk;
  logic rst;

  instruction_fetch_if bus();

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a fixed scramble of the address, with word 0 = 0x13.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  assign bus.imem_data = word_at(bus.imem_addr);

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
    logic        fault;
  } vec_t;

  vec_t tbl[$];
  int   vectors;
  int   miscompares;

  function automatic void add(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc,
                              input logic v, input logic [31:0] pc, input logic req,
                              input logic [31:0] addr, input logic f);
    vec_t e;
    e.rst = r; e.rdy = rdy; e.redir = rd; e.rpc = rpc;
    e.v = v; e.pc = pc; e.req = req; e.addr = addr; e.fault = f;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst                = r;
    bus.if_ready       = rdy;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    #1;
  endtask

  task automatic expect_out(input logic v, input logic [31:0] pc, input logic req,
                            input logic [31:0] addr, input logic f);
    chk("if_valid", 32'(bus.if_valid), 32'(v));
    if (v) begin
      chk("if_pc", bus.if_pc, pc);
      chk("if_instr", bus.if_instr, word_at(pc));
    end
    chk("imem_req", 32'(bus.imem_req), 32'(req));
    chk("imem_addr", bus.imem_addr, addr);
    chk("fetch_fault", 32'(bus.fetch_fault), 32'(f));
  endtask

  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_fault;

  initial begin
    vectors            = 0;
    miscompares        = 0;
    rst                = 1'b1;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Streaming from reset with decode always ready.
    add(1,1,0,0,            0,0,0,0,0);
    add(1,1,0,0,            0,0,0,0,0);
    add(0,1,0,0,            0,0,1,0,0);
    add(0,1,0,0,            1,0,1,32'h4,0);
    add(0,1,0,0,            1,32'h4,1,32'h8,0);
    add(0,1,0,0,            1,32'h8,1,32'hC,0);
    add(0,1,0,0,            1,32'hC,1,32'h10,0);
    // Decode stalled from reset: buffer fills to two, then drains with no gap.
    add(1,0,0,0,            0,0,0,0,0);
    add(0,0,0,0,            0,0,1,0,0);
    add(0,0,0,0,            1,0,1,32'h4,0);
    add(0,0,0,0,            1,0,0,32'h8,0);
    add(0,0,0,0,            1,0,0,32'h8,0);
    add(0,1,0,0,            1,0,0,32'h8,0);
    add(0,1,0,0,            1,32'h4,1,32'h8,0);
    add(0,1,0,0,            1,32'h8,1,32'hC,0);
    add(0,0,0,0,            1,32'hC,1,32'h10,0);
    add(0,0,0,0,            1,32'hC,0,32'h14,0);
    // Redirect while full and popping: stale head discarded.
    add(0,1,1,32'h40,       1,32'hC,0,32'h14,0);
    add(0,1,0,0,            0,0,1,32'h40,0);
    add(0,1,0,0,            1,32'h40,1,32'h44,0);
    // Misaligned redirect faults; aligned redirect recovers.
    add(0,1,1,32'h42,       1,32'h44,0,32'h48,0);
    add(0,1,0,0,            0,0,0,32'h40,1);
    add(0,1,0,0,            0,0,0,32'h40,1);
    add(0,1,1,32'h44,       0,0,0,32'h40,1);
    add(0,1,0,0,            0,0,1,32'h44,0);
    add(0,1,0,0,            1,32'h44,1,32'h48,0);
    // PC wrap, then back-to-back redirects where the last wins.
    add(0,1,1,32'hFFFF_FFFC,1,32'h48,0,32'h4C,0);
    add(0,1,0,0,            0,0,1,32'hFFFF_FFFC,0);
    add(0,1,0,0,            1,32'hFFFF_FFFC,1,32'h0,0);
    add(0,1,0,0,            1,32'h0,1,32'h4,0);
    add(0,1,1,32'h80,       1,32'h4,0,32'h8,0);
    add(0,1,1,32'h100,      0,0,0,32'h80,0);
    add(0,1,0,0,            0,0,1,32'h100,0);
    add(0,1,0,0,            1,32'h100,1,32'h104,0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      expect_out(tbl[i].v, tbl[i].pc, tbl[i].req, tbl[i].addr, tbl[i].fault);
      if (tbl[i].rst) begin
        chk("rst_if_instr", bus.if_instr, 32'h0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
      end
    end

    // Fill two entries, then assert reset between edges: outputs must drop at once.
    apply(0, 0, 0, 0);
    expect_out(1, 32'h104, 1, 32'h108, 0);
    apply(0, 0, 0, 0);
    expect_out(1, 32'h104, 0, 32'h10C, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_if_valid", 32'(bus.if_valid), 32'h0);
    chk("async_rst_imem_req", 32'(bus.imem_req), 32'h0);
    chk("async_rst_imem_addr", bus.imem_addr, 32'h0);
    apply(1, 1, 0, 0);
    expect_out(0, 0, 0, 0, 0);
    apply(0, 1, 0, 0);
    expect_out(0, 0, 1, 0, 0);
    apply(0, 1, 0, 0);
    expect_out(1, 0, 1, 32'h4, 0);
    chk("first_instr_word", bus.if_instr, 32'h0000_0013);

    // Random run against a queue model of the buffer.
    apply(1, 0, 0, 0);
    m_pc    = 32'h0;
    m_fault = 1'b0;
    m_q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic        rdy;
      logic        rd;
      logic [31:0] rpc;
      logic        exp_req;
      rdy = ($urandom_range(0, 99) < 70);
      rd  = ($urandom_range(0, 99) < 6);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      apply(0, rdy, rd, rpc);
      exp_req = !m_fault && !rd && (m_q.size() < DEPTH);
      expect_out(m_q.size() != 0, (m_q.size() != 0) ? m_q[0] : 32'h0, exp_req, m_pc, m_fault);
      if (rd) begin
        m_q.delete();
        m_fault = (rpc[1:0] != 2'b00);
        m_pc    = rpc & 32'hFFFF_FFFC;
      end else begin
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (exp_req) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
